ctrl_cnt_relu_mux: RTL and testbench

Write-back controller stage directly downstream of the output-mux counter. It counts the `inc_relu_mux_cnt` pulses that the output-mux counter raises once per completed sweep of its 4 output-mux inputs. From that count it drives the select of the ReLU-group mux, generates a linear write-back address and write enable for every `act_wb` beat, and signals completion after the last programmed ReLU group has been written. Together with the output-mux counter it lets the FSM write back only the filters actually in use.

---
 rtl/ctrl_cnt_relu_mux_if.sv | 27 ++
 rtl/ctrl_cnt_relu_mux.sv | 99 +++++++++
 tb/tb_ctrl_cnt_relu_mux.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_cnt_relu_mux_if.sv
// Handshake/bus bundle between the write-back controller and its driver.
interface ctrl_cnt_relu_mux_if #(
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned ADDR_W = 10
);
    logic              cnt_clear;
    logic              cnt_load;
    logic [SEL_W:0]    max_grp;
    logic [ADDR_W-1:0] base_addr;
    logic              act_wb;
    logic              inc_relu_mux_cnt;
    logic [SEL_W-1:0]  sel_relu_mux;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_we;
    logic              wb_busy;
    logic              wb_done;

    modport master (
        output cnt_clear, cnt_load, max_grp, base_addr, act_wb, inc_relu_mux_cnt,
        input  sel_relu_mux, wb_addr, wb_we, wb_busy, wb_done
    );

    modport slave (
        input  cnt_clear, cnt_load, max_grp, base_addr, act_wb, inc_relu_mux_cnt,
        output sel_relu_mux, wb_addr, wb_we, wb_busy, wb_done
    );
endinterface

// File: rtl/ctrl_cnt_relu_mux.sv
// Write-back controller: steps the ReLU-group select on each output-mux sweep and
// generates a linear write-back address/enable until the last programmed group is done.
module ctrl_cnt_relu_mux #(
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned ADDR_W = 10
) (
    input logic                clk,
    input logic                rst_n,
    ctrl_cnt_relu_mux_if.slave bus
);
    localparam logic [SEL_W-1:0]  SelOne  = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W:0]    MaxOne  = {{SEL_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StWb, StDone} state_e;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEL_W:0]    max_q, max_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              busy_q, done_q;
    logic              we;
    logic              last_grp;

    assign last_grp = ({1'b0, sel_q} == (max_q - MaxOne));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            addr_q  <= '0;
            max_q   <= MaxOne;
            base_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            max_q   <= max_d;
            base_q  <= base_d;
            busy_q  <= (state_d == StWb);
            done_q  <= (state_d == StDone);
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        max_d   = max_q;
        base_d  = base_q;
        if (bus.cnt_clear) begin
            state_d = StIdle;
            sel_d   = '0;
            addr_d  = base_q;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cnt_load) begin
                        max_d  = (bus.max_grp == '0) ? MaxOne : bus.max_grp;
                        base_d = bus.base_addr;
                        addr_d = bus.base_addr;
                    end else if (bus.act_wb) begin
                        state_d = StWb;
                        addr_d  = addr_q + AddrOne;
                    end
                end
                StWb: begin
                    if (bus.act_wb) addr_d = addr_q + AddrOne;
                    if (bus.inc_relu_mux_cnt) begin
                        if (last_grp) begin
                            sel_d   = '0;
                            state_d = StDone;
                        end else begin
                            sel_d = sel_q + SelOne;
                        end
                    end
                end
                StDone: begin
                    // Reload base so the next pass needs no reprogramming.
                    state_d = StIdle;
                    addr_d  = base_q;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        we               = bus.act_wb & ~bus.cnt_clear & rst_n & (state_q != StDone);
        bus.wb_we        = we;
        bus.wb_addr      = addr_q;
        bus.sel_relu_mux = sel_q;
        bus.wb_busy      = busy_q;
        bus.wb_done      = done_q;
    end
endmodule

// File: tb/tb_ctrl_cnt_relu_mux.sv
// Scoreboard bench: driver pushes expected per-cycle status and write addresses from a
// behavioural model; a negedge monitor pops and compares.
module tb_ctrl_cnt_relu_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ctrl_cnt_relu_mux_if #(.SEL_W(4), .ADDR_W(10)) bus ();

    ctrl_cnt_relu_mux #(.SEL_W(4), .ADDR_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       we;
        logic [9:0] addr;
        logic [3:0] sel;
        logic       busy;
        logic       done;
    } st_t;

    st_t      st_q[$];
    int       wr_q[$];
    int       tests = 0;
    int       fails = 0;

    // Model: phase 0 = idle, 1 = writing back, 2 = finished
    int m_phase, m_grp, m_addr, m_max, m_base;

    task automatic model_reset();
        m_phase = 0; m_grp = 0; m_addr = 0; m_max = 1; m_base = 0;
    endtask

    // Drives one cycle's inputs just after the rising edge and records the expectation.
    task automatic step(input bit rst, input bit clr, input bit ld, input int mg, input int ba,
                        input bit act, input bit inc);
        bit  exp_we;
        st_t e;
        @(posedge clk);
        #1;
        rst_n                = rst;
        bus.cnt_clear        = clr;
        bus.cnt_load         = ld;
        bus.max_grp          = 5'(mg);
        bus.base_addr        = 10'(ba);
        bus.act_wb           = act;
        bus.inc_relu_mux_cnt = inc;
        if (!rst) model_reset();
        exp_we = rst && act && !clr && (m_phase != 2);
        e.we   = exp_we;
        e.addr = 10'(m_addr);
        e.sel  = 4'(m_grp);
        e.busy = (m_phase == 1);
        e.done = (m_phase == 2);
        st_q.push_back(e);
        if (exp_we) wr_q.push_back(m_addr);
        if (rst) begin
            if (clr) begin
                m_phase = 0; m_grp = 0; m_addr = m_base;
            end else if (ld && m_phase == 0) begin
                m_max = (mg == 0) ? 1 : mg;
                m_base = ba; m_addr = ba;
            end else if (m_phase == 2) begin
                m_phase = 0; m_addr = m_base;
            end else begin
                if (exp_we) m_addr = (m_addr + 1) % 1024;
                if (m_phase == 0 && act) m_phase = 1;
                else if (m_phase == 1 && inc) begin
                    if (m_grp + 1 >= m_max) begin
                        m_grp = 0; m_phase = 2;
                    end else m_grp = m_grp + 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        st_t e;
        st_t a;
        int  wa;
        a = {bus.wb_we, bus.wb_addr, bus.sel_relu_mux, bus.wb_busy, bus.wb_done};
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL status t=%0t got we=%b addr=%h sel=%0d busy=%b done=%b, want we=%b addr=%h sel=%0d busy=%b done=%b",
                         $time, a.we, a.addr, a.sel, a.busy, a.done,
                         e.we, e.addr, e.sel, e.busy, e.done);
            end
        end
        if (bus.wb_we === 1'b1) begin
            tests++;
            if (wr_q.size() == 0) begin
                fails++;
                $display("FAIL write t=%0t got unexpected write at %h, want none", $time, bus.wb_addr);
            end else begin
                wa = wr_q.pop_front();
                if (bus.wb_addr !== 10'(wa)) begin
                    fails++;
                    $display("FAIL write_addr t=%0t got %h, want %h", $time, bus.wb_addr, 10'(wa));
                end
            end
        end
    end

    initial begin
        bus.cnt_clear = 0; bus.cnt_load = 0; bus.max_grp = 0; bus.base_addr = 0;
        bus.act_wb = 0; bus.inc_relu_mux_cnt = 0;
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // 1: three groups, twelve beats
        step(1, 0, 1, 3, 'h040, 0, 0);
        for (int b = 1; b <= 12; b++) step(1, 0, 0, 0, 0, 1, (b % 4) == 0);
        idle(3);

        // 2: max_grp 0 behaves as 1
        step(1, 0, 1, 0, 'h100, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        idle(3);

        // 3: clear together with strobes at sel = 2
        step(1, 0, 1, 3, 'h200, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 0, 1, 1);
        idle(2);

        // 4: load in WB ignored
        step(1, 0, 1, 3, 'h000, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 1, 5, 'h155, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1);
        idle(3);

        // 5: address wrap
        step(1, 0, 1, 3, 'h3FE, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(2);

        // 6: asynchronous reset mid-pass
        step(1, 0, 1, 4, 'h0A0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        #1;
        tests++;
        if ({bus.wb_we, bus.wb_addr, bus.sel_relu_mux, bus.wb_busy, bus.wb_done} !== '0) begin
            fails++;
            $display("FAIL async_reset got addr=%h sel=%0d busy=%b done=%b we=%b, want all 0",
                     bus.wb_addr, bus.sel_relu_mux, bus.wb_busy, bus.wb_done, bus.wb_we);
        end
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 1);
        idle(3);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step(1, r < 3, (r >= 3 && r < 8), $urandom_range(0, 16), $urandom_range(0, 1023),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (wr_q.size() != 0 || st_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d writes/%0d status pending, want 0/0",
                     wr_q.size(), st_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
